// File: rtl/icache_refill_ctrl_if.sv
// Bundle of the fetch-lookup, memory-port and cache-fill signals around the I-cache refill
// sequencer. slave is the sequencer's view; master is the surrounding system's view.
interface icache_refill_ctrl_if;
  logic         cpu_valid;
  logic [31:0]  cpu_addr;
  logic         cache_hit;
  logic         stall;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ready;
  logic [31:0]  mem_rdata;
  logic         fill_valid;
  logic [31:0]  fill_addr;
  logic [127:0] fill_data;
  logic         mem_err;
  logic [15:0]  miss_count;
  logic [15:0]  refill_cycles;

  modport slave (
    input  cpu_valid, cpu_addr, cache_hit, mem_ready, mem_rdata,
    output stall, mem_req, mem_addr, fill_valid, fill_addr, fill_data, mem_err,
    output miss_count, refill_cycles
  );

  modport master (
    output cpu_valid, cpu_addr, cache_hit, mem_ready, mem_rdata,
    input  stall, mem_req, mem_addr, fill_valid, fill_addr, fill_data, mem_err,
    input  miss_count, refill_cycles
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Miss/refill sequencer for an 8-line x 128-bit direct-mapped I-cache: fetches a line as four
// 32-bit beats with timeout/retry. Optional miss/refill statistics under ICACHE_STATS_EN.
module icache_refill_ctrl #(
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  icache_refill_ctrl_if.slave         bus_io
);

  if (LINE_WORDS != 4) begin : g_bad_line_words
    $error("LINE_WORDS must be 4 (128-bit line)");
  end
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must be in 2..255");
  end

  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StBeat, StRetry, StFill, StResync} state_e;

  state_e        state_q, state_d;
  logic [1:0]    beat_q, beat_d;
  logic [7:0]    tmo_q, tmo_d;
  logic [31:0]   miss_addr_q, miss_addr_d;
  logic [127:0]  line_q, line_d;
  logic [31:0]   fill_addr_q, fill_addr_d;
  logic [127:0]  fill_data_q, fill_data_d;
  logic          mem_err;
  logic          miss;

  assign miss = bus_io.cpu_valid & ~bus_io.cache_hit;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    tmo_d       = tmo_q;
    miss_addr_d = miss_addr_q;
    line_d      = line_q;
    fill_addr_d = fill_addr_q;
    fill_data_d = fill_data_q;
    mem_err     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (miss) begin
          miss_addr_d = {bus_io.cpu_addr[31:4], 4'b0000};
          beat_d      = 2'd0;
          tmo_d       = 8'd0;
          state_d     = StBeat;
        end
      end
      StBeat: begin
        if (bus_io.mem_ready) begin
          line_d[32*beat_q +: 32] = bus_io.mem_rdata;
          beat_d                  = beat_q + 2'd1;
          tmo_d                   = 8'd0;
          if (beat_q == 2'd3) begin
            fill_data_d = line_d;
            fill_addr_d = miss_addr_q;
            state_d     = StFill;
          end
        end else if (tmo_q == TmoLast) begin
          // Give up on this attempt; the partial line is thrown away.
          mem_err = 1'b1;
          beat_d  = 2'd0;
          tmo_d   = 8'd0;
          line_d  = '0;
          state_d = StRetry;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      StRetry:  state_d = StBeat;
      StFill:   state_d = StResync;
      // Lets the cache's registered hit flag see the new line before we return to IDLE.
      StResync: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      beat_q      <= 2'd0;
      tmo_q       <= 8'd0;
      miss_addr_q <= '0;
      line_q      <= '0;
      fill_addr_q <= '0;
      fill_data_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      tmo_q       <= tmo_d;
      miss_addr_q <= miss_addr_d;
      line_q      <= line_d;
      fill_addr_q <= fill_addr_d;
      fill_data_q <= fill_data_d;
    end
  end

  assign bus_io.stall      = (state_q != StIdle) | miss;
  assign bus_io.mem_req    = (state_q == StBeat);
  assign bus_io.mem_addr   = miss_addr_q;
  assign bus_io.fill_valid = (state_q == StFill);
  assign bus_io.fill_addr  = fill_addr_q;
  assign bus_io.fill_data  = fill_data_q;
  assign bus_io.mem_err    = mem_err;

`ifdef ICACHE_STATS_EN
  logic [15:0] miss_count_q, refill_cycles_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      miss_count_q    <= '0;
      refill_cycles_q <= '0;
    end else begin
      if (state_q == StIdle && state_d == StBeat && miss_count_q != 16'hFFFF) begin
        miss_count_q <= miss_count_q + 16'd1;
      end
      if (state_q != StIdle && refill_cycles_q != 16'hFFFF) begin
        refill_cycles_q <= refill_cycles_q + 16'd1;
      end
    end
  end

  assign bus_io.miss_count    = miss_count_q;
  assign bus_io.refill_cycles = refill_cycles_q;
`else
  assign bus_io.miss_count    = 16'h0000;
  assign bus_io.refill_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl: expected fills are queued at miss time and
// compared when fill_valid is seen; per-cycle handshake checks come from a small refill model.
module tb_icache_refill_ctrl;

  localparam int unsigned Tmo = 4;
`ifdef ICACHE_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
  } fill_t;

  typedef enum int {PBeat, PRetry, PFill, PResync, PDone} phase_e;

  logic clk;
  logic rst_n;
  icache_refill_ctrl_if bus ();

  icache_refill_ctrl #(.TIMEOUT(Tmo)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fill_t exp_q[$];
  int    n_vec    = 0;
  int    n_err    = 0;
  int    n_fills  = 0;
  int    n_pushed = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Fill monitor: every fill strobe must match the oldest outstanding expected line.
  always @(negedge clk) begin
    if (bus.fill_valid === 1'b1) begin
      n_fills++;
      if (exp_q.size() == 0) begin
        check_eq("fill_unexpected", 1'b1, 1'b0);
      end else begin
        fill_t e;
        e = exp_q.pop_front();
        check_eq("fill_addr", bus.fill_addr, e.addr);
        check_eq("fill_data", bus.fill_data, e.data);
      end
    end
  end

  // Runs one miss at addr; rdy_mask bit c drives mem_ready in cycle c (cycle 0 = miss cycle).
  task automatic refill(input logic [31:0] addr, input logic [31:0] base,
                        input logic [31:0] rdy_mask);
    fill_t  e;
    phase_e ph;
    int     beats;
    int     tmo;
    int     c;
    logic   rdy;
    logic   exp_err;
    logic [31:0] line_addr;

    line_addr = {addr[31:4], 4'b0000};
    e.addr = line_addr;
    e.data = {base + 32'd3, base + 32'd2, base + 32'd1, base};
    exp_q.push_back(e);
    n_pushed++;

    @(posedge clk); #1;
    bus.cpu_valid = 1'b1;
    bus.cpu_addr  = addr;
    bus.cache_hit = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check_eq("miss_stall", bus.stall, 1'b1);
    check_eq("miss_cycle_req", bus.mem_req, 1'b0);

    ph = PBeat; beats = 0; tmo = 0; c = 1;
    while (ph != PDone && c < 64) begin
      @(posedge clk); #1;
      bus.cpu_addr  = $urandom;
      rdy           = rdy_mask[c];
      bus.mem_ready = rdy;
      bus.mem_rdata = (ph == PBeat && rdy) ? base + 32'(beats) : (32'hDEAD_0000 | 32'(c));
      exp_err       = (ph == PBeat) && !rdy && (tmo == int'(Tmo) - 1);
      @(negedge clk);
      check_eq("refill_stall", bus.stall, 1'b1);
      check_eq("mem_req", bus.mem_req, ph == PBeat);
      check_eq("mem_err", bus.mem_err, exp_err);
      check_eq("fill_valid", bus.fill_valid, ph == PFill);
      if (ph == PBeat) check_eq("mem_addr", bus.mem_addr, line_addr);
      case (ph)
        PBeat: begin
          if (rdy) begin
            beats++;
            tmo = 0;
            if (beats == 4) ph = PFill;
          end else if (exp_err) begin
            ph = PRetry; beats = 0; tmo = 0;
          end else begin
            tmo++;
          end
        end
        PRetry:  ph = PBeat;
        PFill:   ph = PResync;
        PResync: ph = PDone;
        default: ph = PDone;
      endcase
      c++;
    end
    if (ph != PDone) check_eq("refill_bound", 1'b0, 1'b1);

    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    bus.cpu_addr  = addr;
    bus.cache_hit = 1'b1;
    @(negedge clk);
    check_eq("relookup_stall", bus.stall, 1'b0);
    check_eq("relookup_req", bus.mem_req, 1'b0);
    @(posedge clk); #1;
    bus.cpu_valid = 1'b0;
    bus.cache_hit = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.cpu_valid = 1'b0;
    bus.cpu_addr  = '0;
    bus.cache_hit = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_stall", bus.stall, 1'b0);
    check_eq("rst_mem_req", bus.mem_req, 1'b0);
    check_eq("rst_fill_valid", bus.fill_valid, 1'b0);
    check_eq("rst_mem_err", bus.mem_err, 1'b0);
    check_eq("rst_mem_addr", bus.mem_addr, 32'h0);
    check_eq("rst_fill_addr", bus.fill_addr, 32'h0);
    check_eq("rst_fill_data", bus.fill_data, 128'h0);
    check_eq("rst_miss_count", bus.miss_count, 16'h0);
    check_eq("rst_refill_cycles", bus.refill_cycles, 16'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Hits only.
    bus.cpu_valid = 1'b1;
    bus.cache_hit = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.cpu_addr = $urandom;
      @(negedge clk);
      check_eq("hit_stall", bus.stall, 1'b0);
      check_eq("hit_mem_req", bus.mem_req, 1'b0);
      check_eq("hit_fill_valid", bus.fill_valid, 1'b0);
      @(posedge clk); #1;
    end
    check_eq("hit_miss_count", bus.miss_count, 16'h0);
    bus.cpu_valid = 1'b0;
    bus.cache_hit = 1'b0;

    // Back-to-back beats, then a second miss for the statistics.
    refill(32'h0000_1234, 32'h0000_00A0, 32'h0000_001E);
    refill(32'h0000_2F48, 32'h0000_00B0, 32'h0000_001E);
    check_eq("stats_miss_count", bus.miss_count, Stats ? 16'd2 : 16'd0);
    check_eq("stats_refill_cycles", bus.refill_cycles, Stats ? 16'd12 : 16'd0);

    // Gapped beats on cycles 2,5,6,9; stray mem_ready in FILL/RESYNC must be ignored.
    refill(32'h8000_00FC, 32'h1111_0000, 32'h0000_0E64);

    // Timeout with no response for 4 cycles, stray ready in RETRY, then 4 beats.
    refill(32'h0001_0048, 32'h2222_0000, 32'h0000_03E0);

    // Reset in the middle of a refill after two beats.
    @(posedge clk); #1;
    bus.cpu_valid = 1'b1;
    bus.cpu_addr  = 32'h0000_5678;
    bus.cache_hit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h5555_0000 | 32'(i);
    end
    @(posedge clk); #1;
    rst_n         = 1'b0;
    bus.cpu_valid = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    check_eq("midrst_stall", bus.stall, 1'b0);
    check_eq("midrst_mem_req", bus.mem_req, 1'b0);
    check_eq("midrst_mem_addr", bus.mem_addr, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    refill(32'h0000_5678, 32'h3333_0000, 32'h0000_001E);

    repeat (3) @(posedge clk);
    check_eq("fill_count", n_fills, n_pushed);
    check_eq("fill_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
Miss/refill sequencer for the direct-mapped L1 instruction cache (8 lines × 128-bit, tag = addr[31:7], index = addr[6:4], word offset = addr[3:2]).
- Detects a lookup miss, stalls the CPU and fetches the 16-byte line from the memory port as four 32-bit beats.
- Assembles the beats into the 128-bit line and writes it into the cache with one fill strobe.
- Sits between the fetch stage, the instruction cache and the instruction-memory bus.

Parameters:
TIMEOUT, 64, max cycles in REQ/BEAT without a mem_ready beat before the request is retried (range 2..255).
LINE_WORDS, 4, beats per line; fixed at 4 (128-bit line); any other value is a synthesis error.

Ports:
Clk  input  1  clock; all state changes on the rising edge.
Rst_n  input  1  asynchronous active-low reset.
cpu_valid  input  1  fetch stage has a valid lookup this cycle.
cpu_addr  input  32  fetch address being looked up.
cache_hit  input  1  registered hit flag from the cache for cpu_addr.
stall  output  1  freeze PC/fetch.
mem_req  output  1  line read request to instruction memory.
mem_addr  output  32  line-aligned address {miss_addr[31:4],4'b0}.
mem_ready  input  1  one beat valid on mem_rdata this cycle.
mem_rdata  input  32  beat data, word 0 first.
fill_valid  output  1  one-cycle line write strobe to the cache.
fill_addr  output  32  line address for the fill (cache takes tag and index from it).
fill_data  output  128  assembled line; word k in bits [32k+31:32k].
mem_err  output  1  one-cycle pulse on each timeout.
miss_count  output  16  misses counted (ICACHE_STATS_EN).
refill_cycles  output  16  cycles spent in refill (ICACHE_STATS_EN).

Behaviour:
- Reset: Rst_n low → state IDLE; stall, mem_req, fill_valid and mem_err = 0; mem_addr, fill_addr, fill_data, beat counter, timeout counter and stats = 0. Effective immediately, including mid-refill; a partial line is discarded and no fill is issued.
- stall = (state != IDLE) | (cpu_valid & ~cache_hit), evaluated combinationally. A miss stalls in the same cycle it is seen.
- IDLE:
  - On cpu_valid & ~cache_hit, latch miss_addr = {cpu_addr[31:4],4'b0}.
  - Clear the beat and timeout counters.
  - Go to REQ.
- REQ / BEAT (one state, BEAT):
  - mem_req = 1 and mem_addr = miss_addr, held stable until the last beat has been accepted.
  - Each cycle with mem_ready = 1: store mem_rdata into word slot beat_cnt (2 bits), increment beat_cnt and clear the timeout counter.
  - Beats may be back-to-back or separated by gaps; mem_ready may already be high in the first BEAT cycle.
  - On the 4th beat (beat_cnt == 3 & mem_ready), go to FILL. mem_req drops in FILL.
- Timeout:
  - In BEAT, each cycle without mem_ready increments the timeout counter.
  - On reaching TIMEOUT: pulse mem_err, clear the beat counter, discard collected words and go to RETRY.
- RETRY: mem_req = 0 for exactly one cycle, then BEAT with the same mem_addr.
- FILL:
  - fill_valid = 1 for one cycle, with fill_addr = miss_addr and fill_data = the assembled line.
  - Go to RESYNC.
- RESYNC: one cycle for the cache's registered hit to re-evaluate, then go to IDLE. The re-lookup then hits.
- fill_addr and fill_data hold their last values outside FILL. Consumers must qualify them with fill_valid.
- mem_ready seen outside BEAT is ignored.
- Changes to cpu_addr while stall is high are ignored; the latched miss_addr governs the refill.
- Miss penalty, from the miss cycle (cycle 0) with back-to-back beats:
  - Cycles 1–4: BEAT.
  - Cycle 5: FILL.
  - Cycle 6: RESYNC.
  - Cycle 7: IDLE; stall falls if the lookup now hits.

Optional Feature:
ICACHE_STATS_EN:
- When defined:
  - miss_count increments on each IDLE→BEAT transition.
  - refill_cycles increments on every cycle with state != IDLE.
  - Both counters saturate at 16'hFFFF and reset to 0.
- When undefined: both outputs are tied to 16'h0000 and no counter flops are built.

Test Plan:
- Reset mid-refill: assert Rst_n = 0 after 2 beats → stall = 0, mem_req = 0 immediately. Release reset and re-miss → a full 4-beat refill follows and fill_valid pulses exactly once.
- Miss at cpu_addr = 32'h0000_1234, memory answers 4 back-to-back beats 32'hA0..A3:
  - mem_addr = 32'h0000_1230.
  - fill_valid high in cycle 5, fill_data = {A3,A2,A1,A0}, fill_addr = 32'h0000_1230.
  - stall high in cycles 0–6 and low in cycle 7 when cache_hit = 1.
- Gapped beats (mem_ready on cycles 2, 5, 6, 9) → mem_req stays high through cycle 9, fill_valid in cycle 10, data order preserved.
- Timeout with TIMEOUT = 4 and no mem_ready:
  - mem_err pulses after 4 idle BEAT cycles.
  - mem_req = 0 for exactly 1 cycle, then is reasserted with the same mem_addr.
  - A following 4-beat response completes normally.
- Hits only (cpu_valid = 1, cache_hit = 1 for 20 cycles) → stall = 0, mem_req = 0 and fill_valid = 0 throughout. With ICACHE_STATS_EN, miss_count = 0.
- ICACHE_STATS_EN, two back-to-back-beat misses → miss_count = 2, refill_cycles = 12. Without the macro both outputs read 0.
